// File: rtl/gate_tt_sequencer.sv
// Exhaustive truth-table sequencer for a 2-input gate under test: drives {x,y}=0..3,
// samples z after a settle time, and reports errors. Optional macro: GATE_TT_LOOP_EN.
module gate_tt_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXP_TABLE     = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       z,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int unsigned SCNT_W      = 4;
  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_LAST);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [1:0]        idx, idx_n;
  logic [SCNT_W-1:0] scnt, scnt_n;
  logic              x_n, y_n, busy_n, done_n, pass_n;
  logic [2:0]        err_n;
  logic [3:0]        fv_n;
`ifdef GATE_TT_LOOP_EN
  logic              wrap, wrap_n;
`endif

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= 2'd0;
      scnt      <= '0;
      x         <= 1'b0;
      y         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
`ifdef GATE_TT_LOOP_EN
      wrap      <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      scnt      <= scnt_n;
      x         <= x_n;
      y         <= y_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err_count <= err_n;
      fail_vec  <= fv_n;
`ifdef GATE_TT_LOOP_EN
      wrap      <= wrap_n;
`endif
    end
  end

  // Next-state and next-output logic; outputs trail the state by one register stage
  always_comb begin
    state_n = state;
    idx_n   = idx;
    scnt_n  = scnt;
    x_n     = x;
    y_n     = y;
    err_n   = err_count;
    fv_n    = fail_vec;
`ifdef GATE_TT_LOOP_EN
    wrap_n  = 1'b0;
`endif

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_n   = 2'd0;
          err_n   = 3'd0;
          fv_n    = 4'd0;
          state_n = S_DRIVE;
        end
      end
      S_DRIVE: begin
        x_n     = idx[1];
        y_n     = idx[0];
        scnt_n  = '0;
        state_n = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
      end
      S_SETTLE: begin
        scnt_n = scnt + SCNT_W'(1);
        if (scnt == SCNT_LAST) state_n = S_CHECK;
      end
      S_CHECK: begin
        // z is only ever looked at here, so settle-time glitches are harmless
        if (z != EXP_TABLE[idx]) begin
          fv_n[idx] = 1'b1;
          if (err_count != 3'd7) err_n = err_count + 3'd1;
        end
        if (idx == 2'd3) begin
`ifdef GATE_TT_LOOP_EN
          if (start) begin
            idx_n   = 2'd0;
            wrap_n  = 1'b1;
            state_n = S_DRIVE;
          end else begin
            state_n = S_DONE;
          end
`else
          state_n = S_DONE;
`endif
        end else begin
          idx_n   = idx + 2'd1;
          state_n = S_DRIVE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_CHECK);
`ifdef GATE_TT_LOOP_EN
    done_n = (state == S_DONE) || wrap;
`else
    done_n = (state == S_DONE);
`endif
    pass_n = done_n && (err_count == 3'd0);
  end

endmodule
